// File: rtl/seg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_ctrl_pkg
// Shared definitions for the 7-segment display controller: register address
// map, CTRL bit positions and controller state encoding.
// -----------------------------------------------------------------------------
package seg_ctrl_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_CTRL   = 2'd1,
        ADDR_STATUS = 2'd2,
        ADDR_RSVD   = 2'd3
    } addr_e;

    localparam int CTRL_BLANK = 0;
    localparam int CTRL_TEST  = 1;
    localparam int CTRL_BLINK = 2;
    localparam int CTRL_W     = 3;

    typedef enum logic {
        S_LAMP = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/seg_display_ctrl_blink_timer.sv
// -----------------------------------------------------------------------------
// blink_timer
// Blink prescaler: while en=1 counts 0..DIV-1 and toggles phase on each wrap.
// Dropping en clears both the count and the phase, so a fresh enable always
// starts with the display visible (phase=0).
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   en     in   count enable / synchronous clear when low
//   phase  out  blink phase, 1 = blanked half-period
// -----------------------------------------------------------------------------
module blink_timer #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic phase
);

    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [BW-1:0] r_cnt;
    logic          r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == BW'(DIV - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
// Processor-facing register block for the dual 7-segment display stage.
// Holds DATA/CTRL registers, runs a power-on lamp test, then drives the
// display from CTRL with optional blinking.
//
// Optional feature macro: SEG_BLINK_EN (instantiates the blink prescaler;
// without it CTRL[2] is storage only).
//
// Ports:
//   clk, rst_n          clock / async active-low reset
//   wr_en, rd_en        single-cycle bus strobes
//   addr[1:0]           register address (DATA, CTRL, STATUS, reserved)
//   wdata[7:0]          write data
//   rdata[7:0], rvalid  read data and its one-cycle valid pulse
//   disp_data[7:0]      display value, [7:4] high digit, [3:0] low digit
//   disp_blank          blank both digits
//   disp_test           lamp test (all segments lit)
//   busy                lamp test in progress
//
// State table:
//   S_LAMP | lamp test after reset, test forced on, busy=1
//   S_RUN  | normal display from CTRL, left only by reset
// -----------------------------------------------------------------------------
module seg_display_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter int LAMP_CYCLES = 50_000_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic [7:0] disp_data,
    output logic       disp_blank,
    output logic       disp_test,
    output logic       busy
);

    localparam int LW = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;

    state_e              r_state;
    logic [LW-1:0]       r_lamp_cnt;
    logic [7:0]          r_data;
    logic [CTRL_W-1:0]   r_ctrl;

    logic [7:0]          w_data_next;
    logic [CTRL_W-1:0]   w_ctrl_next;
    logic [7:0]          w_rd_value;
    logic                w_phase;
    logic                w_blank_run;

    // Outputs are computed from the post-write register values so a write
    // shows on disp_* the cycle after wr_en.
    always_comb begin
        w_data_next = r_data;
        w_ctrl_next = r_ctrl;
        if (wr_en) begin
            case (addr)
                ADDR_DATA: w_data_next = wdata;
                ADDR_CTRL: w_ctrl_next = wdata[CTRL_W-1:0];
                default:   ;
            endcase
        end
    end

    // Read mux sees the pre-write values: a same-cycle read+write returns old data.
    always_comb begin
        w_rd_value = 8'h00;
        case (addr)
            ADDR_DATA:   w_rd_value = r_data;
            ADDR_CTRL:   w_rd_value = {{(8 - CTRL_W){1'b0}}, r_ctrl};
            ADDR_STATUS: w_rd_value = {7'b0, (r_state == S_LAMP)};
            default:     w_rd_value = 8'h00;
        endcase
    end

`ifdef SEG_BLINK_EN
    // Enable follows the post-write CTRL so clearing blink_en takes effect
    // on the same edge as the write; LAMP holds the prescaler cleared.
    blink_timer #(
        .DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((r_state == S_RUN) && w_ctrl_next[CTRL_BLINK]),
        .phase (w_phase)
    );
`else
    assign w_phase = 1'b0;
`endif

    // Phase is masked by blink_en so the blank drops immediately when blinking
    // is switched off, even if the prescaler was mid blank half-period.
    assign w_blank_run = w_ctrl_next[CTRL_BLANK] | (w_phase & w_ctrl_next[CTRL_BLINK]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LAMP;
            r_lamp_cnt <= '0;
            r_data     <= 8'h00;
            r_ctrl     <= '0;
            rdata      <= 8'h00;
            rvalid     <= 1'b0;
            disp_data  <= 8'h00;
            disp_blank <= 1'b0;
            disp_test  <= 1'b1;
            busy       <= 1'b1;
        end else begin
            r_data    <= w_data_next;
            r_ctrl    <= w_ctrl_next;
            rvalid    <= rd_en;
            rdata     <= rd_en ? w_rd_value : 8'h00;
            disp_data <= w_data_next;

            case (r_state)
                S_LAMP: begin
                    if (r_lamp_cnt == LW'(LAMP_CYCLES - 1)) begin
                        r_state    <= S_RUN;
                        disp_test  <= w_ctrl_next[CTRL_TEST];
                        disp_blank <= w_blank_run;
                        busy       <= 1'b0;
                    end else begin
                        r_lamp_cnt <= r_lamp_cnt + 1'b1;
                        disp_test  <= 1'b1;
                        disp_blank <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    disp_test  <= w_ctrl_next[CTRL_TEST];
                    disp_blank <= w_blank_run;
                    busy       <= 1'b0;
                end
                default: begin
                    r_state <= S_LAMP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_display_ctrl
// Self-checking bench for seg_display_ctrl (LAMP_CYCLES=8, BLINK_DIV=4).
// A reference model tracks elapsed edges since reset, register contents and
// time since blinking was enabled, and predicts every output after each edge.
// -----------------------------------------------------------------------------
module tb_seg_display_ctrl;

    localparam int LAMP = 8;
    localparam int DIV  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       rvalid;
    logic [7:0] disp_data;
    logic       disp_blank;
    logic       disp_test;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         m_edges;
    logic [7:0] m_data;
    logic [2:0] m_ctrl;
    int         m_blink_k;
    logic [7:0] e_rdata;
    logic       e_rvalid;
    logic [7:0] e_disp_data;
    logic       e_blank;
    logic       e_test;
    logic       e_busy;

    seg_display_ctrl #(
        .LAMP_CYCLES (LAMP),
        .BLINK_DIV   (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .disp_data  (disp_data),
        .disp_blank (disp_blank),
        .disp_test  (disp_test),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rdata"},      rdata,              e_rdata);
        check({tag, ".rvalid"},     {7'b0, rvalid},     {7'b0, e_rvalid});
        check({tag, ".disp_data"},  disp_data,          e_disp_data);
        check({tag, ".disp_blank"}, {7'b0, disp_blank}, {7'b0, e_blank});
        check({tag, ".disp_test"},  {7'b0, disp_test},  {7'b0, e_test});
        check({tag, ".busy"},       {7'b0, busy},       {7'b0, e_busy});
    endtask

    task automatic model_reset();
        m_edges     = 0;
        m_data      = 8'h00;
        m_ctrl      = 3'b000;
        m_blink_k   = -1;
        e_rdata     = 8'h00;
        e_rvalid    = 1'b0;
        e_disp_data = 8'h00;
        e_blank     = 1'b0;
        e_test      = 1'b1;
        e_busy      = 1'b1;
    endtask

    // Predict outputs after one rising edge with the given bus inputs.
    task automatic model_edge(input logic wr, input logic rd, input logic [1:0] a,
                              input logic [7:0] wd);
        bit run_before, run_after, en;
        logic [7:0] rv;
        run_before = (m_edges >= LAMP);
        case (a)
            2'd0:    rv = m_data;
            2'd1:    rv = {5'b0, m_ctrl};
            2'd2:    rv = {7'b0, !run_before};
            default: rv = 8'h00;
        endcase
        e_rvalid = rd;
        e_rdata  = rd ? rv : 8'h00;
        if (wr && a == 2'd0) m_data = wd;
        if (wr && a == 2'd1) m_ctrl = wd[2:0];
        m_edges++;
        run_after = (m_edges >= LAMP);
        en = run_before && m_ctrl[2];
        m_blink_k = en ? m_blink_k + 1 : -1;
        e_disp_data = m_data;
        e_busy = !run_after;
        e_test = run_after ? m_ctrl[1] : 1'b1;
        e_blank = 1'b0;
        if (run_after) begin
            e_blank = m_ctrl[0];
`ifdef SEG_BLINK_EN
            if (en && ((m_blink_k / DIV) % 2 == 1)) e_blank = 1'b1;
`endif
        end
    endtask

    task automatic step(input string tag, input logic wr, input logic rd,
                        input logic [1:0] a, input logic [7:0] wd);
        wr_en = wr;
        rd_en = rd;
        addr  = a;
        wdata = wd;
        @(posedge clk);
        model_edge(wr, rd, a, wd);
        #1;
        check_all(tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    // Async reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #4 rst_n = 1'b1;

        // lamp test then idle RUN
        idle("lamp", LAMP + 2);

        // DATA write/read in RUN
        step("wr_data_3c", 1'b1, 1'b0, 2'd0, 8'h3C);
        step("rd_data",    1'b0, 1'b1, 2'd0, 8'h00);
        idle("rd_gap", 1);

        // write during LAMP
        pulse_reset("reset2");
        idle("lamp2", 2);
        step("wr_lamp_a5", 1'b1, 1'b0, 2'd0, 8'hA5);
        idle("lamp2_end", LAMP);
        step("rd_status_run", 1'b0, 1'b1, 2'd2, 8'h00);

        // CTRL blank/test
        step("ctrl_blank", 1'b1, 1'b0, 2'd1, 8'h01);
        step("ctrl_test",  1'b1, 1'b0, 2'd1, 8'h02);
        step("rd_ctrl",    1'b0, 1'b1, 2'd1, 8'h00);
        step("wr_status",  1'b1, 1'b0, 2'd2, 8'hFF);
        step("wr_rsvd",    1'b1, 1'b1, 2'd3, 8'hFF);

        // blink, then off mid blanked half-period
        step("blink_on", 1'b1, 1'b0, 2'd1, 8'h04);
        idle("blink", 3 * DIV + 1);
        step("blink_off", 1'b1, 1'b0, 2'd1, 8'h00);
        idle("blink_off_idle", 2);

        // same-cycle read and write
        step("wr_11",   1'b1, 1'b0, 2'd0, 8'h11);
        step("rdwr_22", 1'b1, 1'b1, 2'd0, 8'h22);
        step("rd_22",   1'b0, 1'b1, 2'd0, 8'h00);

        // randomized traffic, with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic       w, r;
            logic [1:0] a;
            logic [7:0] d;
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) == 0);
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            if (a == 2'd1 && $urandom_range(0, 1) == 0) d[2] = 1'b1;
            if ($urandom_range(0, 150) == 0) pulse_reset("rnd_reset");
            step("rnd", w, r, a, d);
        end

        // reset mid-blink: lamp restarts
        idle("pre_blink", LAMP);
        step("blink_on2", 1'b1, 1'b0, 2'd1, 8'h04);
        idle("blink2", DIV + 2);
        pulse_reset("reset_mid_blink");
        idle("lamp3", LAMP + 2);
        step("rd_data_after_reset", 1'b0, 1'b1, 2'd0, 8'h00);
        step("rd_status_after",     1'b0, 1'b1, 2'd2, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
